// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration upload scheduler.
//   - FSM state encoding
//   - default bank address/data widths
//   - register map of the sensor configuration bank
package cfg_pkg;

  localparam int unsigned CFG_ADDR_W = 3;
  localparam int unsigned CFG_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_TX    = 2'd3
  } cfg_state_e;

  // Sensor configuration register map
  localparam logic [CFG_ADDR_W-1:0] REG_CTRL     = 3'd0;
  localparam logic [CFG_ADDR_W-1:0] REG_EXPOSURE = 3'd1;
  localparam logic [CFG_ADDR_W-1:0] REG_GAIN     = 3'd2;
  localparam logic [CFG_ADDR_W-1:0] REG_WIN_X    = 3'd3;
  localparam logic [CFG_ADDR_W-1:0] REG_WIN_Y    = 3'd4;
  localparam logic [CFG_ADDR_W-1:0] REG_FPS      = 3'd5;
  localparam logic [CFG_ADDR_W-1:0] REG_TEST     = 3'd6;
  localparam logic [CFG_ADDR_W-1:0] REG_RSVD     = 3'd7;
  localparam int unsigned           CFG_NUM_REGS = 8;

endpackage

// File: rtl/cfg_upload_scheduler_if.sv
// Bus bundle of the upload scheduler: I2C write path, transmitter read path
// and the single shared port of the configuration register bank.
//   master : requesters + bank (drive requests and reg_rdata)
//   slave  : scheduler (drives acks, read data, bank strobes)
interface cfg_upload_scheduler_if #(
  parameter int AW = cfg_pkg::CFG_ADDR_W,
  parameter int DW = cfg_pkg::CFG_DATA_W
);
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          reg_we;
  logic          reg_re;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, reg_rdata,
    input  wr_ack, rd_data, rd_valid, reg_we, reg_re, reg_addr, reg_wdata
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, reg_rdata,
    output wr_ack, rd_data, rd_valid, reg_we, reg_re, reg_addr, reg_wdata
  );
endinterface

// File: rtl/cfg_port_arbiter.sv
// Arbitration of the single register bank port.
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   write_allowed_i  : FSM permits a write this cycle
//   bus              : scheduler side of the bus bundle
// Reads always win: the read request is a one-cycle pulse and cannot wait,
// while the write requester holds its request until acknowledged.
module cfg_port_arbiter #(
  parameter int AW = 3,
  parameter int DW = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic write_allowed_i,
  cfg_upload_scheduler_if.slave bus
);

  logic          rd_grant;
  logic          wr_grant;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;
  logic          rd_valid_q;

  // Strobes are combinational so the bank sees them in the request cycle;
  // they are held low during reset.
  always_comb begin
    rd_grant  = rst_n_i & bus.rd_req;
    wr_grant  = rst_n_i & bus.wr_req & write_allowed_i & ~bus.rd_req;
    addr_mux  = '0;
    wdata_mux = '0;
    if (rd_grant) begin
      addr_mux = bus.rd_addr;
    end else if (wr_grant) begin
      addr_mux  = bus.wr_addr;
      wdata_mux = bus.wr_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) rd_valid_q <= 1'b0;
    else          rd_valid_q <= rd_grant;
  end

  assign bus.reg_re    = rd_grant;
  assign bus.reg_we    = wr_grant;
  assign bus.wr_ack    = wr_grant;
  assign bus.reg_addr  = addr_mux;
  assign bus.reg_wdata = wdata_mux;
  assign bus.rd_valid  = rd_valid_q;
  // Bank data arrives the cycle after the strobe, together with rd_valid.
  assign bus.rd_data   = rd_valid_q ? bus.reg_rdata : '0;

endmodule

// File: rtl/cfg_upload_scheduler.sv
// Configuration upload scheduler.
//   clk_i, rst_n_i   : system clock, synchronous active-low reset
//   frame_start_i    : one-cycle frame pulse
//   tx_end_i         : one-cycle completion pulse from the transmitter
//   config_start_o   : one-cycle pulse launching an upload
//   busy_o           : high in DELAY and TX
//   tx_error_o       : sticky transmitter timeout flag
//   bus              : write/read request paths and bank port
// Tracks a dirty flag, launches one upload per eligible frame a fixed delay
// after the frame pulse and supervises completion with a timeout.
module cfg_upload_scheduler
  import cfg_pkg::*;
#(
  parameter int G_ADDR_WIDTH     = CFG_ADDR_W,
  parameter int G_DATA_WIDTH     = CFG_DATA_W,
  parameter int G_START_DELAY    = 64,
  parameter int G_TX_TIMEOUT     = 4096,
  parameter int G_REFRESH_FRAMES = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic frame_start_i,
  input  logic tx_end_i,
  output logic config_start_o,
  output logic busy_o,
  output logic tx_error_o,
  cfg_upload_scheduler_if.slave bus
);

  localparam int TO_W = $clog2(G_TX_TIMEOUT + 1);

  cfg_state_e      state_q;
  logic [15:0]     dly_q;
  logic [TO_W-1:0] to_q;
  logic [7:0]      fcnt_q;
  logic [7:0]      fcnt_nxt;
  logic            dirty_q;
  logic            cs_q;
  logic            busy_q;
  logic            err_q;
  logic            refresh_due;
  logic            write_allowed;

  always_comb begin
    refresh_due = (G_REFRESH_FRAMES > 0) && (fcnt_q == 8'(G_REFRESH_FRAMES - 1));
    if (G_REFRESH_FRAMES == 0) fcnt_nxt = '0;
    else if (refresh_due)      fcnt_nxt = '0;
    else                       fcnt_nxt = fcnt_q + 8'd1;
    // A write racing the launching frame pulse stalls; dirty is already set.
    write_allowed = (state_q == ST_IDLE) ||
                    ((state_q == ST_ARMED) && !frame_start_i);
  end

  cfg_port_arbiter #(.AW(G_ADDR_WIDTH), .DW(G_DATA_WIDTH)) u_arb (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .write_allowed_i (write_allowed),
    .bus             (bus)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      to_q    <= '0;
      fcnt_q  <= '0;
      dirty_q <= 1'b1;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cs_q <= 1'b0;
      if (bus.wr_ack) dirty_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (frame_start_i) fcnt_q <= fcnt_nxt;
          if (dirty_q || refresh_due) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (frame_start_i) begin
            busy_q <= 1'b1;
            if (G_START_DELAY <= 1) begin
              state_q <= ST_TX;
              cs_q    <= 1'b1;
              dirty_q <= 1'b0;
              to_q    <= '0;
              fcnt_q  <= '0;
            end else begin
              // Loaded with delay-1: the last decrement lands on the edge
              // that enters TX, giving exactly G_START_DELAY cycles.
              state_q <= ST_DELAY;
              dly_q   <= 16'(G_START_DELAY - 1);
              fcnt_q  <= fcnt_nxt;
            end
          end
        end
        ST_DELAY: begin
          if (dly_q <= 16'd1) begin
            state_q <= ST_TX;
            dly_q   <= '0;
            cs_q    <= 1'b1;
            dirty_q <= 1'b0;
            to_q    <= '0;
            fcnt_q  <= '0;
          end else begin
            dly_q <= dly_q - 16'd1;
          end
        end
        ST_TX: begin
          if (tx_end_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (to_q == TO_W'(G_TX_TIMEOUT - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            dirty_q <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign config_start_o = cs_q;
  assign busy_o         = busy_q;
  assign tx_error_o     = err_q;

endmodule

// File: tb/tb_cfg_upload_scheduler.sv
// Scoreboard bench for cfg_upload_scheduler: stimulus pushes expected
// CONFIG_START cycles, read data and write commits; a negedge monitor pops
// and compares whenever the DUT presents the corresponding output.
module tb_cfg_upload_scheduler;
  import cfg_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_start;
  logic tx_end;
  logic config_start;
  logic busy;
  logic tx_error;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   both_hi = 0;

  cfg_upload_scheduler_if #(.AW(3), .DW(16)) bus ();

  cfg_upload_scheduler #(
    .G_ADDR_WIDTH(3), .G_DATA_WIDTH(16), .G_START_DELAY(64),
    .G_TX_TIMEOUT(4096), .G_REFRESH_FRAMES(8)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .frame_start_i  (frame_start),
    .tx_end_i       (tx_end),
    .config_start_o (config_start),
    .busy_o         (busy),
    .tx_error_o     (tx_error),
    .bus            (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank model: synchronous write, read data one cycle after strobe.
  logic [15:0] mem [0:7] = '{16'hC000, 16'hC001, 16'hC002, 16'hC003,
                             16'hC004, 16'hC005, 16'hC006, 16'hC007};
  always @(posedge clk) begin
    if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
  end

  typedef struct { int cyc; logic [15:0] data; } rd_exp_t;
  typedef struct { int cyc; logic [2:0] addr; logic [15:0] data; } wr_exp_t;
  int      exp_cs_q [$];
  rd_exp_t exp_rd_q [$];
  wr_exp_t exp_wr_q [$];
  int      mon_e;
  rd_exp_t mon_r;
  wr_exp_t mon_w;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (bus.reg_we && bus.reg_re) both_hi++;
    if (config_start) begin
      checks++;
      if (exp_cs_q.size() == 0) begin
        errors++;
        $display("FAIL config_start: unexpected pulse at cycle %0d", cyc);
      end else begin
        mon_e = exp_cs_q.pop_front();
        if (mon_e != cyc) begin
          errors++;
          $display("FAIL config_start cycle: got %0d expected %0d", cyc, mon_e);
        end
      end
    end
    if (bus.rd_valid) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_valid: unexpected at cycle %0d data %h", cyc, bus.rd_data);
      end else begin
        mon_r = exp_rd_q.pop_front();
        if (mon_r.cyc != cyc || bus.rd_data !== mon_r.data) begin
          errors++;
          $display("FAIL read: got cycle %0d data %h expected cycle %0d data %h",
                   cyc, bus.rd_data, mon_r.cyc, mon_r.data);
        end
      end
    end
    if (bus.wr_ack) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_ack: unexpected at cycle %0d", cyc);
      end else begin
        mon_w = exp_wr_q.pop_front();
        if (mon_w.cyc != cyc || bus.reg_we !== 1'b1 ||
            bus.reg_addr !== mon_w.addr || bus.reg_wdata !== mon_w.data) begin
          errors++;
          $display("FAIL write: got cycle %0d we %b addr %0d data %h expected cycle %0d addr %0d data %h",
                   cyc, bus.reg_we, bus.reg_addr, bus.reg_wdata, mon_w.cyc, mon_w.addr, mon_w.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
  endtask

  task automatic pulse_tx_end();
    tx_end = 1'b1; tick(1); tx_end = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp);
    exp_rd_q.push_back('{cyc + 1, exp});
    bus.rd_req = 1'b1; bus.rd_addr = a;
    tick(1);
    bus.rd_req = 1'b0;
  endtask

  task automatic write_txn(input logic [2:0] a, input logic [15:0] d, input int exp_cyc);
    int n = 0;
    exp_wr_q.push_back('{exp_cyc, a, d});
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    forever begin
      @(negedge clk);
      if (bus.wr_ack) break;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL wr_ack timeout: addr %0d", a);
        break;
      end
    end
    tick(1);
    bus.wr_req = 1'b0;
  endtask

  // One frame period; optionally expects an upload and answers it.
  task automatic frame_cycle(input bit up, input string nm);
    int t;
    t = cyc;
    if (up) exp_cs_q.push_back(t + 64);
    pulse_frame();
    @(negedge clk);
    chk({nm, " busy"}, busy, up);
    wait_cyc(t + 90);
    if (up) pulse_tx_end();
    wait_cyc(t + 120);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, c;
    rst_n = 1'b0; frame_start = 1'b0; tx_end = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    tick(3);
    // Reset state; a read request during reset must not strobe the bank
    bus.rd_req = 1'b1; bus.rd_addr = REG_GAIN;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst tx_error", tx_error, 0);
    chk("rst config_start", config_start, 0);
    chk("rst reg_re", bus.reg_re, 0);
    chk("rst rd_valid", bus.rd_valid, 0);
    tick(1);
    bus.rd_req = 1'b0;
    rst_n = 1'b1;

    // First frame after reset uploads (dirty=1 out of reset)
    wait_cyc(10);
    exp_cs_q.push_back(74);
    pulse_frame();
    @(negedge clk);
    chk("t1 busy in delay", busy, 1);
    wait_cyc(274);
    pulse_tx_end();
    @(negedge clk);
    chk("t1 busy after tx_end", busy, 0);

    // Clean: refresh every 8th frame (frame 1 also proves dirty was cleared)
    wait_cyc(300);
    for (int k = 1; k <= 16; k++) frame_cycle(k == 8 || k == 16, $sformatf("refresh f%0d", k));

    // Write held across TX is stalled until the cycle after TX_END
    write_txn(REG_EXPOSURE, 16'h1111, cyc);
    tick(3);
    t = cyc;
    exp_cs_q.push_back(t + 64);
    pulse_frame();
    wait_cyc(t + 70);
    fork
      write_txn(REG_FPS, 16'hBEEF, t + 101);
      begin
        wait_cyc(t + 80);
        @(negedge clk);
        chk("wr_ack withheld in TX", bus.wr_ack, 0);
        wait_cyc(t + 100);
        pulse_tx_end();
      end
    join
    tick(5);
    frame_cycle(1, "upload after stalled write");

    // Simultaneous read and write: read first, write one cycle later
    c = cyc;
    fork
      write_txn(REG_WIN_X, 16'h00A5, c + 1);
      rd(REG_GAIN, 16'hC002);
      begin
        @(negedge clk);
        chk("arb reg_re", bus.reg_re, 1);
        chk("arb reg_we", bus.reg_we, 0);
      end
    join
    tick(1);
    rd(REG_WIN_X, 16'h00A5);
    rd(REG_EXPOSURE, 16'h1111);
    rd(REG_FPS, 16'hBEEF);
    tick(5);

    // Timeout: no TX_END; a read in DELAY is still served
    t = cyc;
    exp_cs_q.push_back(t + 64);
    pulse_frame();
    wait_cyc(t + 10);
    rd(REG_CTRL, 16'hC000);
    wait_cyc(t + 64 + 4095);
    @(negedge clk);
    chk("to tx_error before", tx_error, 0);
    chk("to busy before", busy, 1);
    wait_cyc(t + 64 + 4096);
    @(negedge clk);
    chk("to tx_error set", tx_error, 1);
    chk("to busy cleared", busy, 0);
    tick(1);
    pulse_tx_end();
    tick(5);
    frame_cycle(1, "retry after timeout");
    chk("tx_error sticky", tx_error, 1);

    // Reset mid-DELAY aborts; next frame re-runs the full delay
    write_txn(REG_TEST, 16'h0606, cyc);
    tick(3);
    t = cyc;
    pulse_frame();
    wait_cyc(t + 20);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid rst busy", busy, 0);
    chk("mid rst tx_error", tx_error, 0);
    chk("mid rst config_start", config_start, 0);
    wait_cyc(t + 40);
    t = cyc;
    exp_cs_q.push_back(t + 64);
    pulse_frame();
    wait_cyc(t + 30);
    pulse_tx_end();
    wait_cyc(t + 63);
    @(negedge clk);
    chk("tx_end in delay ignored", busy, 1);
    wait_cyc(t + 90);
    pulse_tx_end();
    @(negedge clk);
    chk("post-reset upload done", busy, 0);

    tick(10);
    chk("pending config_start", exp_cs_q.size(), 0);
    chk("pending reads", exp_rd_q.size(), 0);
    chk("pending writes", exp_wr_q.size(), 0);
    chk("reg_we and reg_re together", both_hi, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_upload_scheduler.md
Name: cfg_upload_scheduler

Overview:
Schedules sensor configuration uploads in the SYS_CLOCK (48 MHz) domain. It owns the single shared port of the configuration register bank and arbitrates it between the I2C slave write path and the config transmitter read path. It tracks register changes with a dirty flag and launches one upload per eligible frame, a fixed delay after FRAME_START. It then waits for TX_END, with a timeout.

Parameters:
G_ADDR_WIDTH, 3, register bank address width
G_DATA_WIDTH, 16, register bank data width
G_START_DELAY, 64, CLOCK cycles from FRAME_START to CONFIG_START (1..65535)
G_TX_TIMEOUT, 4096, CLOCK cycles allowed between CONFIG_START and TX_END
G_REFRESH_FRAMES, 8, force an upload every N frames even when clean; 0 disables

Ports:
CLOCK  in  1  system clock, 48 MHz
RESET_N  in  1  synchronous reset, active low
FRAME_START  in  1  one-cycle pulse, already synchronised to CLOCK
WR_REQ  in  1  I2C write request, held until WR_ACK
WR_ADDR  in  G_ADDR_WIDTH  write address
WR_DATA  in  G_DATA_WIDTH  write data
WR_ACK  out  1  one-cycle pulse: write committed to the bank
RD_REQ  in  1  transmitter read request, one-cycle pulse
RD_ADDR  in  G_ADDR_WIDTH  read address
RD_DATA  out  G_DATA_WIDTH  read data
RD_VALID  out  1  one-cycle pulse, RD_DATA valid
REG_WE  out  1  bank write strobe
REG_RE  out  1  bank read strobe
REG_ADDR  out  G_ADDR_WIDTH  bank address
REG_WDATA  out  G_DATA_WIDTH  bank write data
REG_RDATA  in  G_DATA_WIDTH  bank read data; valid 1 cycle after REG_RE
CONFIG_START  out  1  one-cycle pulse to the config transmitter
TX_END  in  1  one-cycle pulse from the transmitter on completion
BUSY  out  1  high in DELAY and TX
TX_ERROR  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Clock and reset: one clock, CLOCK. RESET_N is synchronous and active low.
- Reset values: all outputs 0, state IDLE. dirty=1, so the first frame after reset uploads. Frame counter = 0.
- States:
  - IDLE: wait for an upload.
  - ARMED: upload pending, waiting for FRAME_START.
  - DELAY: counting down G_START_DELAY.
  - TX: CONFIG_START issued, waiting for TX_END.
- Transitions:
  - IDLE->ARMED when dirty=1, or when refresh is due (frame counter == G_REFRESH_FRAMES-1 with G_REFRESH_FRAMES>0).
  - ARMED->DELAY on FRAME_START; load the delay counter.
  - DELAY->TX when the counter reaches 0. Pulse CONFIG_START for one cycle on entry to TX. Clear dirty in that same cycle.
  - TX->IDLE on TX_END.
  - TX->IDLE on timeout after G_TX_TIMEOUT cycles without TX_END. On timeout, set TX_ERROR and set dirty=1 so the upload is retried.
- Frame counter: increments on every FRAME_START and wraps at G_REFRESH_FRAMES-1. Reset to 0 whenever an upload starts.
- FRAME_START seen in DELAY or TX is ignored; no re-trigger.
- Write gating: writes are accepted only in IDLE and ARMED. In DELAY and TX, WR_ACK is withheld, so the requester stalls and the uploaded configuration is never torn.
- Accepted write: REG_WE=1 with address and data, WR_ACK pulses in the same cycle, and dirty is set.
- Reads are accepted in any state. REG_RE=1 in the request cycle. One cycle later RD_VALID=1 and RD_DATA=REG_RDATA, registered at that edge.
- Arbitration when RD_REQ and WR_REQ are both high in the same cycle: the read wins and the write waits at least 1 cycle. Read priority is fixed because RD_REQ is a pulse and cannot be stalled.
- Port exclusivity: REG_WE and REG_RE are never high together.
- Write on the FRAME_START cycle in ARMED: the state moves to DELAY and the write stalls. Dirty was already 1, so no loss.
- Write acknowledged in the same cycle as IDLE->ARMED: it is accepted.
- TX_END arriving outside TX is ignored.
- Reset mid-upload: return to IDLE with dirty=1; no CONFIG_START is issued during reset.
- Widths: the delay counter is 16 bits, the timeout counter is ceil(log2(G_TX_TIMEOUT+1)) bits, and the frame counter is 8 bits. Counters saturate, never wrap, in DELAY and TX.

Decomposition:
- Shared package cfg_pkg holds:
  - the state encoding (IDLE=2'd0, ARMED=2'd1, DELAY=2'd2, TX=2'd3);
  - the G_ADDR_WIDTH and G_DATA_WIDTH defaults;
  - the register map constants.
- One natural sub-module: cfg_port_arbiter, the read/write arbitration and bank strobes. It takes a write_allowed input from the FSM. The FSM and counters stay in the top level.

Test Plan:
- Reset, then FRAME_START at cycle 10 -> CONFIG_START exactly 64 cycles later; TX_END at +200 -> BUSY low, IDLE; dirty cleared.
- Clean, G_REFRESH_FRAMES=8, 16 FRAME_STARTs, no writes -> exactly 2 CONFIG_STARTs, on frames 8 and 16.
- WR_REQ held during TX -> no WR_ACK until the cycle after TX_END; the write then commits and the next FRAME_START triggers an upload.
- RD_REQ and WR_REQ in the same cycle (addr 2 read, addr 3 write 16'h00A5) -> REG_RE first, RD_VALID next cycle with the bank value, WR_ACK on a later cycle, REG_WE/REG_RE never both high.
- No TX_END after CONFIG_START -> TX_ERROR=1 at cycle 4096 after it, state IDLE; the next FRAME_START re-launches the upload and TX_ERROR stays 1.
- RESET_N low for 1 cycle mid-DELAY -> outputs 0; the next FRAME_START re-runs the full 64-cycle delay.
